minimac2_rxframer: RTL and testbench
====================================

MINIMAC2_RXFRAMER -- requirements
Module: minimac2_rxframer

Interface
REQ-001 The block SHALL have parameter max_bytes, default 1536, giving the maximum accepted frame length in bytes, FCS included.
REQ-002 The block SHALL have parameter min_bytes, default 64, giving the minimum accepted frame length in bytes, FCS included.
REQ-003 The block SHALL use one clock, phy_rx_clk, and one reset, phy_rx_rst, which is synchronous and active-high.
REQ-004 Ports (name  direction  width  meaning) SHALL be:
- phy_rx_clk  in  1  PHY receive clock; the only clock.
- phy_rx_rst  in  1  synchronous active-high reset.
- phy_dv  in  1  MII receive data valid.
- phy_rx_data  in  4  MII receive nibble.
- phy_rx_er  in  1  MII receive error.
- out_dat  out  8  assembled byte.
- out_stb  out  1  out_dat valid, one-cycle pulse.
- out_sof  out  1  asserted together with out_stb on the first byte after the SFD.
- frame_end  out  1  one-cycle pulse at the end of a frame.
- frame_good  out  1  frame accepted; valid during frame_end.
- err_crc  out  1  FCS mismatch; valid during frame_end.
- err_phy  out  1  phy_rx_er was seen during the frame; valid during frame_end.
- err_len  out  1  runt or oversize frame; valid during frame_end.
- err_align  out  1  odd nibble count; valid during frame_end.
- byte_count  out  11  bytes received, saturating at max_bytes; valid during frame_end.

Function
REQ-005 The block SHALL implement the states IDLE, PREAMBLE, DATA and DROP, plus an armed flag.
REQ-006 IDLE: if armed and phy_dv=1 and phy_rx_data=4'h5, go to PREAMBLE; if armed and phy_dv=1 with any other nibble, go to DROP; otherwise stay in IDLE.
REQ-007 PREAMBLE transitions SHALL be:
- phy_dv=0: go to IDLE, with no frame_end.
- nibble 4'h5: stay in PREAMBLE.
- nibble 4'hD (SFD): go to DATA; clear the nibble phase, byte counter and error flags; load CRC with 32'hFFFFFFFF.
- any other nibble: go to DROP.
REQ-008 DATA: nibbles SHALL arrive low nibble first, and out_dat SHALL be {high, low}.
REQ-009 out_stb SHALL pulse one cycle after the high nibble is sampled; out_sof SHALL accompany the first such pulse only.
REQ-010 The CRC SHALL be reflected CRC-32 (poly 32'hEDB88320), updated per byte, LSB first, over all bytes including the FCS.
REQ-011 A correct frame SHALL leave the CRC register at residue 32'hDEBB20E3.
REQ-012 byte_count SHALL increment once per completed byte.
REQ-013 When a byte completes with byte_count already equal to max_bytes:
- err_len is set;
- that byte and all later bytes produce no out_stb;
- byte_count holds at max_bytes;
- CRC checking is still evaluated, but the frame is bad.
REQ-014 phy_rx_er=1 while in DATA with phy_dv=1 SHALL set err_phy.
REQ-015 phy_dv=0 while in DATA SHALL end the frame: go to IDLE, and pulse frame_end on the next cycle.
REQ-016 At that end of frame, err_align SHALL be set if the nibble phase was odd; the partial nibble SHALL be discarded, with no out_stb.
REQ-017 At that end of frame, err_len SHALL be set if byte_count < min_bytes.
REQ-018 At that end of frame, err_crc SHALL be set if the residue differs from 32'hDEBB20E3.
REQ-019 frame_good SHALL equal NOT(err_crc OR err_phy OR err_len OR err_align).
REQ-020 Status outputs (frame_good, err_*, byte_count) SHALL be registered, and SHALL hold from frame_end until the next SFD.
REQ-021 DROP: stay in DROP while phy_dv=1; go to IDLE when phy_dv=0; produce no out_stb and no frame_end.
REQ-022 The armed flag SHALL be set by any cycle with phy_dv=0.
REQ-023 The armed flag SHALL prevent a frame from being accepted when phy_dv is already high coming out of reset.
REQ-024 If the last byte's out_stb and frame_end would coincide, out_stb SHALL occur first and frame_end exactly one cycle later.
REQ-025 Bytes SHALL never be reordered or duplicated.

Reset
REQ-026 phy_rx_rst SHALL force IDLE and clear armed.
REQ-027 phy_rx_rst SHALL clear out_stb, out_sof, frame_end, frame_good, every err_* output and byte_count to 0, and set out_dat to 8'h00.
REQ-028 Reset asserted mid-frame SHALL abort the frame silently, with no frame_end.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Good frame: 15 nibbles 4'h5, then 4'hD, then a 64-byte frame with valid FCS -> 64 out_stb, out_sof on the first only, out_dat matches byte for byte, then frame_end with frame_good=1, byte_count=64, all err_*=0.
- Bad CRC: the same frame with one payload bit flipped -> frame_end with err_crc=1, frame_good=0, byte_count=64.
- PHY error: phy_rx_er pulsed for one cycle at byte 20 -> err_phy=1, frame_good=0, and all 64 bytes still strobed.
- Length limits: 60-byte valid-FCS frame -> err_len=1, byte_count=60; a 1540-byte frame -> exactly 1536 out_stb, err_len=1, byte_count=1536.
- Alignment: 64 bytes plus one extra nibble -> 64 out_stb, err_align=1, frame_good=0.
- Reset mid-frame: reset at byte 10 with phy_dv held high and the frame continuing -> no out_stb, no frame_end; after phy_dv falls, the next good frame is received with frame_good=1.
- Bad preamble: preamble 4'h5 followed by nibble 4'h3 -> DROP, no outputs until phy_dv falls.

Source files
------------

// File: rtl/minimac2_rxframer.sv
// rtl/minimac2_rxframer.sv - MII receive framer: preamble/SFD detection, nibble-to-byte assembly,
// FCS residue, length, alignment and PHY error checks with registered per-frame status.
module minimac2_rxframer #(
  parameter int unsigned max_bytes = 1536,
  parameter int unsigned min_bytes = 64
) (
  input  logic        phy_rx_clk,
  input  logic        phy_rx_rst,
  input  logic        phy_dv,
  input  logic [3:0]  phy_rx_data,
  input  logic        phy_rx_er,
  output logic [7:0]  out_dat,
  output logic        out_stb,
  output logic        out_sof,
  output logic        frame_end,
  output logic        frame_good,
  output logic        err_crc,
  output logic        err_phy,
  output logic        err_len,
  output logic        err_align,
  output logic [10:0] byte_count
);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MAX_CNT     = 11'(max_bytes);
  localparam logic [10:0] MIN_CNT     = 11'(min_bytes);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        phy_err_q, phy_err_d;
  logic        over_q, over_d;
  logic        first_q, first_d;
  logic [7:0]  dat_q, dat_d;
  logic        stb_q, stb_d, sof_q, sof_d, end_q, end_d;
  logic        good_q, good_d, ecrc_q, ecrc_d, ephy_q, ephy_d;
  logic        elen_q, elen_d, ealign_q, ealign_d;
  logic [10:0] bcnt_q, bcnt_d;

  logic [7:0]  byte_w;
  logic [31:0] crc_next;
  logic        end_len, end_crc;

  assign byte_w  = {phy_rx_data, low_q};
  assign end_len = over_q | (cnt_q < MIN_CNT);
  assign end_crc = (crc_q != CRC_RESIDUE);

  // Reflected CRC-32 advanced by one byte, LSB first.
  always_comb begin
    crc_next = crc_q ^ {24'h000000, byte_w};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | ~phy_dv;
    phase_d   = phase_q;
    low_d     = low_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    phy_err_d = phy_err_q;
    over_d    = over_q;
    first_d   = first_q;
    dat_d     = dat_q;
    stb_d     = 1'b0;
    sof_d     = 1'b0;
    end_d     = 1'b0;
    good_d    = good_q;
    ecrc_d    = ecrc_q;
    ephy_d    = ephy_q;
    elen_d    = elen_q;
    ealign_d  = ealign_q;
    bcnt_d    = bcnt_q;
    case (state_q)
      IDLE: begin
        if (armed_q && phy_dv) state_d = (phy_rx_data == 4'h5) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!phy_dv) begin
          state_d = IDLE;
        end else if (phy_rx_data == 4'hD) begin
          state_d   = DATA;
          phase_d   = 1'b0;
          cnt_d     = '0;
          phy_err_d = 1'b0;
          over_d    = 1'b0;
          first_d   = 1'b1;
          crc_d     = 32'hFFFFFFFF;
        end else if (phy_rx_data != 4'h5) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!phy_dv) begin
          // Strobes are one cycle behind the nibble, so the last byte always precedes frame_end.
          state_d  = IDLE;
          end_d    = 1'b1;
          ealign_d = phase_q;
          elen_d   = end_len;
          ecrc_d   = end_crc;
          ephy_d   = phy_err_q;
          good_d   = ~(end_len | end_crc | phy_err_q | phase_q);
          bcnt_d   = cnt_q;
        end else begin
          if (phy_rx_er) phy_err_d = 1'b1;
          if (!phase_q) begin
            low_d   = phy_rx_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc_next;
            if (cnt_q == MAX_CNT) begin
              over_d = 1'b1;
            end else begin
              cnt_d   = cnt_q + 11'd1;
              dat_d   = byte_w;
              stb_d   = 1'b1;
              sof_d   = first_q;
              first_d = 1'b0;
            end
          end
        end
      end
      DROP: begin
        if (!phy_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phy_rx_clk) begin
    if (phy_rx_rst) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      phase_q   <= 1'b0;
      low_q     <= 4'h0;
      cnt_q     <= '0;
      crc_q     <= 32'hFFFFFFFF;
      phy_err_q <= 1'b0;
      over_q    <= 1'b0;
      first_q   <= 1'b0;
      dat_q     <= 8'h00;
      stb_q     <= 1'b0;
      sof_q     <= 1'b0;
      end_q     <= 1'b0;
      good_q    <= 1'b0;
      ecrc_q    <= 1'b0;
      ephy_q    <= 1'b0;
      elen_q    <= 1'b0;
      ealign_q  <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      phase_q   <= phase_d;
      low_q     <= low_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      phy_err_q <= phy_err_d;
      over_q    <= over_d;
      first_q   <= first_d;
      dat_q     <= dat_d;
      stb_q     <= stb_d;
      sof_q     <= sof_d;
      end_q     <= end_d;
      good_q    <= good_d;
      ecrc_q    <= ecrc_d;
      ephy_q    <= ephy_d;
      elen_q    <= elen_d;
      ealign_q  <= ealign_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign out_dat    = dat_q;
  assign out_stb    = stb_q;
  assign out_sof    = sof_q;
  assign frame_end  = end_q;
  assign frame_good = good_q;
  assign err_crc    = ecrc_q;
  assign err_phy    = ephy_q;
  assign err_len    = elen_q;
  assign err_align  = ealign_q;
  assign byte_count = bcnt_q;
endmodule

// File: tb/tb_minimac2_rxframer.sv
// tb/tb_minimac2_rxframer.sv - randomized self-checking bench for minimac2_rxframer
module tb_minimac2_rxframer;
  localparam int MAXB = 1536;
  localparam int MINB = 64;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [3:0]  d;
  logic        er;
  logic [7:0]  out_dat;
  logic        out_stb, out_sof, frame_end, frame_good;
  logic        err_crc, err_phy, err_len, err_align;
  logic [10:0] byte_count;

  always #5 clk = ~clk;

  minimac2_rxframer dut (
    .phy_rx_clk (clk),
    .phy_rx_rst (rst),
    .phy_dv     (dv),
    .phy_rx_data(d),
    .phy_rx_er  (er),
    .out_dat    (out_dat),
    .out_stb    (out_stb),
    .out_sof    (out_sof),
    .frame_end  (frame_end),
    .frame_good (frame_good),
    .err_crc    (err_crc),
    .err_phy    (err_phy),
    .err_len    (err_len),
    .err_align  (err_align),
    .byte_count (byte_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  rx_q[$];
  bit          sof_q[$];
  int          fe_cnt = 0;
  logic        cap_good, cap_crc, cap_phy, cap_len, cap_align;
  logic [10:0] cap_cnt;

  always @(negedge clk) begin
    if (out_stb) begin
      rx_q.push_back(out_dat);
      sof_q.push_back(out_sof);
    end
    if (frame_end) begin
      fe_cnt++;
      cap_good  = frame_good;
      cap_crc   = err_crc;
      cap_phy   = err_phy;
      cap_len   = err_len;
      cap_align = err_align;
      cap_cnt   = byte_count;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nib(input logic v, input logic [3:0] n, input logic e);
    @(negedge clk);
    dv = v;
    d  = n;
    er = e;
  endtask

  task automatic gap(input int n);
    repeat (n) nib(1'b0, 4'h0, 1'b0);
  endtask

  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t make_frame(input int n);
    bq_t b;
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) b.push_back(8'($urandom));
    f = crc32(b, n - 4);
    for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
    return b;
  endfunction

  task automatic send_bytes(input bq_t b, input int from, input int er_at);
    for (int i = from; i < b.size(); i++) begin
      nib(1'b1, b[i][3:0], (i == er_at));
      nib(1'b1, b[i][7:4], 1'b0);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    sof_q.delete();
    fe_cnt = 0;
  endtask

  // Expected results come from whole-frame properties: length, appended FCS, flags injected.
  task automatic run_frame(input string tag, input bq_t b, input int npre, input bit extra, input int er_at);
    int n, exp_n, mism, sofs;
    bit e_crc, e_len, e_phy, e_al, e_good;
    logic [31:0] fcs;
    clear_mon();
    repeat (npre) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    send_bytes(b, 0, er_at);
    if (extra) nib(1'b1, 4'($urandom), 1'b0);
    gap(4);
    n      = b.size();
    exp_n  = (n > MAXB) ? MAXB : n;
    fcs    = {b[n-1], b[n-2], b[n-3], b[n-4]};
    e_crc  = (crc32(b, n - 4) != fcs);
    e_len  = (n < MINB) || (n > MAXB);
    e_phy  = (er_at >= 0) && (er_at < n);
    e_al   = extra;
    e_good = !(e_crc || e_len || e_phy || e_al);
    check({tag, " n_stb"}, rx_q.size(), exp_n);
    mism = 0;
    for (int i = 0; i < rx_q.size() && i < n; i++) if (rx_q[i] !== b[i]) mism++;
    check({tag, " data_mismatches"}, mism, 0);
    sofs = 0;
    foreach (sof_q[i]) if (sof_q[i]) sofs++;
    check({tag, " sof_count"}, sofs, 1);
    check({tag, " sof_first"}, (sof_q.size() > 0) ? 32'(sof_q[0]) : 32'd0, 1);
    check({tag, " frame_end_count"}, fe_cnt, 1);
    check({tag, " frame_good"}, cap_good, e_good);
    check({tag, " err_crc"}, cap_crc, e_crc);
    check({tag, " err_phy"}, cap_phy, e_phy);
    check({tag, " err_len"}, cap_len, e_len);
    check({tag, " err_align"}, cap_align, e_al);
    check({tag, " byte_count"}, cap_cnt, exp_n);
  endtask

  bq_t gf, bf;
  int  len, er_at;
  bit  extra;

  initial begin
    rst = 1'b1; dv = 1'b1; d = 4'h5; er = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset out_stb", out_stb, 0);
    check("reset out_sof", out_sof, 0);
    check("reset frame_end", frame_end, 0);
    check("reset status", {frame_good, err_crc, err_phy, err_len, err_align}, 0);
    check("reset byte_count", byte_count, 0);
    check("reset out_dat", out_dat, 8'h00);

    // Leaving reset with phy_dv already high: the frame in flight must be ignored.
    @(negedge clk); rst = 1'b0;
    gf = make_frame(64);
    repeat (10) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    send_bytes(gf, 0, -1);
    gap(4);
    check("unarmed n_stb", rx_q.size(), 0);
    check("unarmed frame_end_count", fe_cnt, 0);

    gf = make_frame(64);
    run_frame("good", gf, 15, 1'b0, -1);
    bf = gf;
    bf[10] = bf[10] ^ 8'h04;
    run_frame("bad_crc", bf, 15, 1'b0, -1);
    run_frame("phy_err", gf, 15, 1'b0, 20);
    run_frame("runt60", make_frame(60), 15, 1'b0, -1);
    run_frame("over1540", make_frame(1540), 15, 1'b0, -1);
    run_frame("align", gf, 15, 1'b1, -1);

    // Reset in the middle of byte 10 while the frame keeps streaming.
    clear_mon();
    gf = make_frame(64);
    repeat (15) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 10; i++) begin
      nib(1'b1, gf[i][3:0], 1'b0);
      nib(1'b1, gf[i][7:4], 1'b0);
    end
    @(negedge clk); rst = 1'b1; d = gf[10][3:0];
    @(negedge clk); rst = 1'b0; d = gf[10][7:4];
    check("rst_mid out_stb", out_stb, 0);
    check("rst_mid pre_bytes", rx_q.size(), 10);
    send_bytes(gf, 11, -1);
    gap(4);
    check("rst_mid n_stb_total", rx_q.size(), 10);
    check("rst_mid frame_end_count", fe_cnt, 0);
    run_frame("after_rst", make_frame(64), 15, 1'b0, -1);

    // Bad preamble: the rest of the burst, even a valid SFD and frame, is discarded.
    clear_mon();
    repeat (6) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'h3, 1'b0);
    repeat (4) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    send_bytes(make_frame(64), 0, -1);
    gap(4);
    check("bad_pre n_stb", rx_q.size(), 0);
    check("bad_pre frame_end_count", fe_cnt, 0);
    run_frame("after_drop", make_frame(64), 15, 1'b0, -1);

    for (int t = 0; t < 20; t++) begin
      len   = $urandom_range(120, 56);
      gf    = make_frame(len);
      if ($urandom_range(3, 0) == 0) gf[$urandom_range(len - 1, 0)] ^= 8'(1 << $urandom_range(7, 0));
      er_at = ($urandom_range(5, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
      extra = ($urandom_range(5, 0) == 0);
      run_frame($sformatf("rand%0d", t), gf, $urandom_range(15, 1), extra, er_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
